// File: rtl/vga_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_ctrl_pkg
// Description : Shared types and default timing constants for the colour
//               controller and its button conditioners.
//               - btn_state_t : button FSM state encoding
//               - c_*         : default timing values at a 50 MHz system clock
// Revision    : 1.0 - initial release
// ============================================================================
package vga_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2
    } btn_state_t;

    // 10 ms debounce, 0.5 s before the first repeat, then 10 repeats per second
    localparam int c_DEBOUNCE_CYCLES     = 500000;
    localparam int c_REPEAT_DELAY_CYCLES = 25000000;
    localparam int c_REPEAT_RATE_CYCLES  = 5000000;
    localparam int c_CNT_W               = 25;

endpackage : vga_ctrl_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a single asynchronous input.
//               Ports: clk   - destination clock
//                      rst_n - asynchronous active-low reset (clears both FFs)
//                      i_d   - asynchronous input level
//                      o_q   - input level, two clk cycles later
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Conditions one raw push-button for the colour controller:
//               2-FF synchroniser, counter-based debounce, registered
//               press/release strobes and optional auto-repeat.
//               Ports: Clk           - system clock
//                      Reset         - asynchronous active-low reset
//                      signalInput   - raw button level, active-high
//                      repeat_en     - 1 enables auto-repeat while held
//                      level         - debounced button level
//                      pulse         - 1-cycle strobe on press / each repeat
//                      release_pulse - 1-cycle strobe on release
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import vga_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = c_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = c_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = c_REPEAT_RATE_CYCLES,
    parameter int CNT_W               = c_CNT_W
) (
    input  logic Clk,
    input  logic Reset,
    input  logic signalInput,
    input  logic repeat_en,
    output logic level,
    output logic pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DLY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_RPT_LAST = CNT_W'(REPEAT_RATE_CYCLES - 1);

    logic             w_s;
    logic             w_accept;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] r_dcnt;
    logic             r_level;

    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_rcnt;
    logic [CNT_W-1:0] w_rcnt_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic             r_release;
    logic             w_release_nxt;

    sync_2ff u_sync (
        .clk   (Clk),
        .rst_n (Reset),
        .i_d   (signalInput),
        .o_q   (w_s)
    );

    // ------------------------------------------------------------------
    // Debounce: s must differ from level for DEBOUNCE_CYCLES consecutive
    // cycles; any return to the current level clears the count.
    // ------------------------------------------------------------------
    assign w_accept = (w_s != r_level) && (r_dcnt == c_DEB_LAST);
    assign w_rise   = w_accept &&  w_s;
    assign w_fall   = w_accept && !w_s;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_dcnt  <= '0;
            r_level <= 1'b0;
        end else if (w_s == r_level) begin
            r_dcnt  <= '0;
        end else if (w_accept) begin
            r_level <= w_s;
            r_dcnt  <= '0;
        end else begin
            r_dcnt  <= r_dcnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Press / hold / repeat FSM. The strobes are computed from the accept
    // condition so they register on the same edge that updates level.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_rcnt_nxt    = r_rcnt;
        w_pulse_nxt   = 1'b0;
        w_release_nxt = 1'b0;

        // A release takes priority over a coincident repeat tick
        if (w_fall) begin
            w_state_nxt   = IDLE;
            w_rcnt_nxt    = '0;
            w_release_nxt = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_rcnt_nxt = '0;
                    if (w_rise) begin
                        w_state_nxt = HOLD_DELAY;
                        w_pulse_nxt = 1'b1;
                    end
                end
                HOLD_DELAY: begin
                    if (!repeat_en) begin
                        w_rcnt_nxt = '0;
                    end else if (r_rcnt >= c_DLY_LAST) begin
                        w_state_nxt = HOLD_REPEAT;
                        w_rcnt_nxt  = '0;
                        w_pulse_nxt = 1'b1;
                    end else begin
                        w_rcnt_nxt  = r_rcnt + 1'b1;
                    end
                end
                HOLD_REPEAT: begin
                    if (!repeat_en) begin
                        w_state_nxt = HOLD_DELAY;
                        w_rcnt_nxt  = '0;
                    end else if (r_rcnt >= c_RPT_LAST) begin
                        w_rcnt_nxt  = '0;
                        w_pulse_nxt = 1'b1;
                    end else begin
                        w_rcnt_nxt  = r_rcnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_rcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_rcnt    <= '0;
            r_pulse   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_pulse   <= w_pulse_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign level         = r_level;
    assign pulse         = r_pulse;
    assign release_pulse = r_release;

endmodule : button_conditioner
`default_nettype wire
